// File: rtl/ex_mem_stage.sv
// Purpose: MIPS execute stage (forwarding, ALU, shifter) plus the EX/MEM pipeline register.
// Latency: one cycle; EX inputs sampled at a posedge appear on mem_* right after that edge.
// Backpressure: none, the stage never stalls; Flush turns the instruction entering MEM into a bubble.
//
// Ports:
//   Clk, Rst (sync, active high), Flush
//   ex_*   : ID/EX register outputs (operands, rs/rt/rd, immediate, shamt, control)
//   wb_*   : WB stage write port, used as the second forwarding source
//   mem_*  : registered result, store data, destination, memory/writeback control, overflow
module ex_mem_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Flush,
    input  logic [31:0] ex_busA,
    input  logic [31:0] ex_busB,
    input  logic [4:0]  ex_Ra,
    input  logic [4:0]  ex_Rb,
    input  logic [4:0]  ex_Rw,
    input  logic [31:0] ex_imm16Ext,
    input  logic [4:0]  ex_shf,
    input  logic        ex_RegWr,
    input  logic        ex_RegDst,
    input  logic        ex_ALUsrc,
    input  logic        ex_MemtoReg,
    input  logic        ex_ALUshf,
    input  logic [1:0]  ex_MemWr,
    input  logic [1:0]  ex_MemRead,
    input  logic [3:0]  ex_ALUctr,
    input  logic        wb_RegWr,
    input  logic [4:0]  wb_Rw,
    input  logic [31:0] wb_busW,
    output logic [31:0] mem_ALUout,
    output logic [31:0] mem_busB,
    output logic [4:0]  mem_Rw,
    output logic        mem_RegWr,
    output logic        mem_MemtoReg,
    output logic        mem_Ovf,
    output logic [1:0]  mem_MemWr,
    output logic [1:0]  mem_MemRead
);

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        ovf;
    logic        mem_fwd_ok;
    logic [4:0]  dest;

    // A load sitting in MEM has no data yet; the upstream load-use bubble
    // guarantees nobody needs it, so only ALU results in MEM are forwarded.
    assign mem_fwd_ok = mem_RegWr && !mem_MemtoReg && (mem_Rw != 5'd0);

    always_comb begin
        fwd_a = ex_busA;
        if (mem_fwd_ok && (mem_Rw == ex_Ra))
            fwd_a = mem_ALUout;
        else if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == ex_Ra))
            fwd_a = wb_busW;
    end

    always_comb begin
        fwd_b = ex_busB;
        if (mem_fwd_ok && (mem_Rw == ex_Rb))
            fwd_b = mem_ALUout;
        else if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == ex_Rb))
            fwd_b = wb_busW;
    end

    assign alu_b = ex_ALUsrc ? ex_imm16Ext : fwd_b;
    assign sum   = fwd_a + alu_b;
    assign diff  = fwd_a - alu_b;
    assign dest  = ex_RegDst ? ex_Rw : ex_Rb;

    // ALUctr[2] selects the variable-shift forms, which take the amount from rs.
    assign shamt = ex_ALUctr[2] ? fwd_a[4:0] : ex_shf;

    always_comb begin
        result = 32'd0;
        ovf    = 1'b0;
        if (ex_ALUshf) begin
            case (ex_ALUctr)
                4'b0000, 4'b0100: result = fwd_b << shamt;
                4'b0001, 4'b0101: result = fwd_b >> shamt;
                4'b0010, 4'b0110: result = $signed(fwd_b) >>> shamt;
                default:          result = 32'd0;
            endcase
        end else begin
            case (ex_ALUctr)
                4'b0000: result = sum;
                4'b0001: begin
                    result = sum;
                    ovf    = (fwd_a[31] == alu_b[31]) && (sum[31] != fwd_a[31]);
                end
                4'b0010: result = diff;
                4'b0011: begin
                    result = diff;
                    ovf    = (fwd_a[31] != alu_b[31]) && (diff[31] != fwd_a[31]);
                end
                4'b0100: result = fwd_a & alu_b;
                4'b0101: result = fwd_a | alu_b;
                4'b0110: result = fwd_a ^ alu_b;
                4'b0111: result = ~(fwd_a | alu_b);
                4'b1000: result = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
                4'b1001: result = {31'd0, (fwd_a < alu_b)};
                4'b1010: result = {alu_b[15:0], 16'd0};
                default: result = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_ALUout   <= 32'd0;
            mem_busB     <= 32'd0;
            mem_Rw       <= 5'd0;
            mem_RegWr    <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_Ovf      <= 1'b0;
            mem_MemWr    <= 2'b00;
            mem_MemRead  <= 2'b00;
        end else begin
            // Data fields load even on Flush; only control is squashed.
            mem_ALUout   <= result;
            mem_busB     <= fwd_b;
            mem_Rw       <= dest;
            mem_RegWr    <= ex_RegWr && !ovf && !Flush;
            mem_MemtoReg <= ex_MemtoReg && !Flush;
            mem_Ovf      <= ovf && !Flush;
            mem_MemWr    <= Flush ? 2'b00 : ex_MemWr;
            mem_MemRead  <= Flush ? 2'b00 : ex_MemRead;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Purpose: directed self-checking bench for ex_mem_stage.
// Latency: each step applies one instruction and checks mem_* one clock later.
// Backpressure: not applicable; the stage never stalls.
module tb_ex_mem_stage;

    logic        Clk;
    logic        Rst;
    logic        Flush;
    logic [31:0] ex_busA;
    logic [31:0] ex_busB;
    logic [4:0]  ex_Ra;
    logic [4:0]  ex_Rb;
    logic [4:0]  ex_Rw;
    logic [31:0] ex_imm16Ext;
    logic [4:0]  ex_shf;
    logic        ex_RegWr;
    logic        ex_RegDst;
    logic        ex_ALUsrc;
    logic        ex_MemtoReg;
    logic        ex_ALUshf;
    logic [1:0]  ex_MemWr;
    logic [1:0]  ex_MemRead;
    logic [3:0]  ex_ALUctr;
    logic        wb_RegWr;
    logic [4:0]  wb_Rw;
    logic [31:0] wb_busW;
    logic [31:0] mem_ALUout;
    logic [31:0] mem_busB;
    logic [4:0]  mem_Rw;
    logic        mem_RegWr;
    logic        mem_MemtoReg;
    logic        mem_Ovf;
    logic [1:0]  mem_MemWr;
    logic [1:0]  mem_MemRead;

    int n_assert = 0;
    int n_fail   = 0;

    ex_mem_stage dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .ex_busA(ex_busA), .ex_busB(ex_busB),
        .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rw(ex_Rw),
        .ex_imm16Ext(ex_imm16Ext), .ex_shf(ex_shf),
        .ex_RegWr(ex_RegWr), .ex_RegDst(ex_RegDst), .ex_ALUsrc(ex_ALUsrc),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUshf(ex_ALUshf),
        .ex_MemWr(ex_MemWr), .ex_MemRead(ex_MemRead), .ex_ALUctr(ex_ALUctr),
        .wb_RegWr(wb_RegWr), .wb_Rw(wb_Rw), .wb_busW(wb_busW),
        .mem_ALUout(mem_ALUout), .mem_busB(mem_busB), .mem_Rw(mem_Rw),
        .mem_RegWr(mem_RegWr), .mem_MemtoReg(mem_MemtoReg), .mem_Ovf(mem_Ovf),
        .mem_MemWr(mem_MemWr), .mem_MemRead(mem_MemRead)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Clear all stimulus to a bubble with no WB write.
    task automatic nop();
        Flush = 0; ex_busA = 0; ex_busB = 0; ex_Ra = 0; ex_Rb = 0; ex_Rw = 0;
        ex_imm16Ext = 0; ex_shf = 0; ex_RegWr = 0; ex_RegDst = 0; ex_ALUsrc = 0;
        ex_MemtoReg = 0; ex_ALUshf = 0; ex_MemWr = 0; ex_MemRead = 0; ex_ALUctr = 0;
        wb_RegWr = 0; wb_Rw = 0; wb_busW = 0;
    endtask

    // R-type ALU op writing rd.
    task automatic rop(input logic [3:0] ctr, input logic [4:0] ra, input logic [31:0] a,
                       input logic [4:0] rb, input logic [31:0] b, input logic [4:0] rw);
        nop();
        ex_ALUctr = ctr; ex_Ra = ra; ex_busA = a; ex_Rb = rb; ex_busB = b;
        ex_Rw = rw; ex_RegDst = 1; ex_RegWr = 1;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"},   mem_ALUout, 32'd0);
        chk({tag, "_busb"},  mem_busB, 32'd0);
        chk({tag, "_rw"},    32'(mem_Rw), 32'd0);
        chk({tag, "_regwr"}, 32'(mem_RegWr), 32'd0);
        chk({tag, "_m2r"},   32'(mem_MemtoReg), 32'd0);
        chk({tag, "_ovf"},   32'(mem_Ovf), 32'd0);
        chk({tag, "_memwr"}, 32'(mem_MemWr), 32'd0);
        chk({tag, "_memrd"}, 32'(mem_MemRead), 32'd0);
    endtask

    initial begin
        // Reset with busy random inputs for two cycles.
        nop();
        Rst = 1;
        for (int i = 0; i < 2; i++) begin
            ex_busA = $urandom; ex_busB = $urandom; ex_imm16Ext = $urandom;
            ex_Ra = 5'($urandom); ex_Rb = 5'($urandom); ex_Rw = 5'($urandom);
            ex_RegWr = 1; ex_MemtoReg = 1; ex_MemWr = 2'b11; ex_MemRead = 2'b10;
            ex_ALUctr = 4'b0001;
            step();
        end
        chk_all_zero("reset");

        // First instruction after reset: ADDU 5 + 7.
        Rst = 0;
        rop(4'b0000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd10);
        step();
        chk("addu_alu", mem_ALUout, 32'd12);
        chk("addu_rw", 32'(mem_Rw), 32'd10);
        chk("addu_regwr", 32'(mem_RegWr), 32'd1);
        chk("addu_ovf", 32'(mem_Ovf), 32'd0);

        // addu $3,$1,$2 then subu $4,$3,$1 with stale busA.
        rop(4'b0000, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
        step();
        chk("dep1_alu", mem_ALUout, 32'd3);
        rop(4'b0010, 5'd3, 32'd0, 5'd1, 32'd1, 5'd4);
        step();
        chk("exfwd_alu", mem_ALUout, 32'd2);
        chk("exfwd_rw", 32'(mem_Rw), 32'd4);

        // MEM beats WB; both operands name $3.
        rop(4'b0000, 5'd1, 32'd10, 5'd2, 32'd20, 5'd3);
        step();
        rop(4'b0000, 5'd3, 32'd0, 5'd3, 32'd0, 5'd5);
        wb_RegWr = 1; wb_Rw = 5'd3; wb_busW = 32'd99;
        step();
        chk("prio_alu", mem_ALUout, 32'd60);
        chk("prio_busb", mem_busB, 32'd30);

        // WB-only forwarding: MEM now holds $5.
        rop(4'b0000, 5'd3, 32'd0, 5'd0, 32'd0, 5'd6);
        wb_RegWr = 1; wb_Rw = 5'd3; wb_busW = 32'd99;
        step();
        chk("wbfwd_alu", mem_ALUout, 32'd99);

        // Writes to $0 are never forwarded from MEM or WB.
        rop(4'b0000, 5'd1, 32'd7, 5'd2, 32'd8, 5'd0);
        step();
        chk("r0w_regwr", 32'(mem_RegWr), 32'd1);
        rop(4'b0000, 5'd0, 32'd0, 5'd2, 32'd5, 5'd11);
        wb_RegWr = 1; wb_Rw = 5'd0; wb_busW = 32'd77;
        step();
        chk("r0_alu", mem_ALUout, 32'd5);

        // Signed overflow on ADD, none on ADDU, overflow on SUB.
        rop(4'b0001, 5'd8, 32'h7FFF_FFFF, 5'd9, 32'd1, 5'd12);
        step();
        chk("add_ovf_alu", mem_ALUout, 32'h8000_0000);
        chk("add_ovf_flag", 32'(mem_Ovf), 32'd1);
        chk("add_ovf_regwr", 32'(mem_RegWr), 32'd0);
        rop(4'b0000, 5'd8, 32'h7FFF_FFFF, 5'd9, 32'd1, 5'd12);
        step();
        chk("addu_novf_flag", 32'(mem_Ovf), 32'd0);
        chk("addu_novf_regwr", 32'(mem_RegWr), 32'd1);
        rop(4'b0011, 5'd8, 32'h8000_0000, 5'd9, 32'd1, 5'd13);
        step();
        chk("sub_ovf_alu", mem_ALUout, 32'h7FFF_FFFF);
        chk("sub_ovf_flag", 32'(mem_Ovf), 32'd1);

        // Shifts and compares.
        rop(4'b0010, 5'd8, 32'd0, 5'd9, 32'h8000_0000, 5'd13);
        ex_ALUshf = 1; ex_shf = 5'd4;
        step();
        chk("sra", mem_ALUout, 32'hF800_0000);
        rop(4'b0101, 5'd8, 32'd36, 5'd9, 32'h8000_0000, 5'd13);
        ex_ALUshf = 1; ex_shf = 5'd1;
        step();
        chk("srlv", mem_ALUout, 32'h0800_0000);
        rop(4'b1000, 5'd8, 32'hFFFF_FFFF, 5'd9, 32'd1, 5'd13);
        step();
        chk("slt", mem_ALUout, 32'd1);
        rop(4'b1001, 5'd8, 32'hFFFF_FFFF, 5'd9, 32'd1, 5'd13);
        step();
        chk("sltu", mem_ALUout, 32'd0);
        rop(4'b1010, 5'd0, 32'd0, 5'd13, 32'd0, 5'd0);
        ex_RegDst = 0; ex_ALUsrc = 1; ex_imm16Ext = 32'h0000_1234;
        step();
        chk("lui_alu", mem_ALUout, 32'h1234_0000);
        chk("lui_rw", 32'(mem_Rw), 32'd13);

        // Flushed store: control squashed, data still loads.
        nop();
        ex_Ra = 5'd8; ex_busA = 32'd100; ex_Rb = 5'd9; ex_busB = 32'hDEAD_BEEF;
        ex_ALUsrc = 1; ex_imm16Ext = 32'd4; ex_MemWr = 2'b11; Flush = 1;
        step();
        chk("flush_memwr", 32'(mem_MemWr), 32'd0);
        chk("flush_regwr", 32'(mem_RegWr), 32'd0);
        chk("flush_alu", mem_ALUout, 32'd104);
        chk("flush_busb", mem_busB, 32'hDEAD_BEEF);

        // Following load is unaffected by the earlier flush.
        nop();
        ex_Ra = 5'd8; ex_busA = 32'd100; ex_Rb = 5'd14; ex_ALUsrc = 1; ex_imm16Ext = 32'd8;
        ex_MemRead = 2'b11; ex_MemtoReg = 1; ex_RegWr = 1;
        step();
        chk("load_alu", mem_ALUout, 32'd108);
        chk("load_memrd", 32'(mem_MemRead), 32'd3);
        chk("load_m2r", 32'(mem_MemtoReg), 32'd1);
        chk("load_regwr", 32'(mem_RegWr), 32'd1);
        chk("load_rw", 32'(mem_Rw), 32'd14);

        // A load in MEM is not a forwarding source.
        rop(4'b0000, 5'd14, 32'd1, 5'd15, 32'd2, 5'd16);
        step();
        chk("noloadfwd_alu", mem_ALUout, 32'd3);

        // Bubble passes through as a bubble.
        nop();
        step();
        chk("bubble_regwr", 32'(mem_RegWr), 32'd0);
        chk("bubble_ovf", 32'(mem_Ovf), 32'd0);
        chk("bubble_memwr", 32'(mem_MemWr), 32'd0);

        // Reset wins over Flush.
        rop(4'b0000, 5'd1, 32'd3, 5'd2, 32'd4, 5'd7);
        ex_MemWr = 2'b01; Flush = 1; Rst = 1;
        step();
        chk_all_zero("rst_flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
